board_b_d_gfx_arb: RTL
======================

# board_b_d_gfx_arb

Single-clock arbiter sharing one 64-bit graphics-ROM SDRAM port between the three B-D playfield tile fetchers. Round-robin scheduling uses a toggle handshake on both sides. A one-line (64-bit) read buffer per requester serves repeat fetches of the same line without an SDRAM access. It sits between the playfield layers and the top-level SDRAM controller channel.

## Interface
Parameters:
- BASE_ADDR, 25'h0: byte address of the tile-graphics region in SDRAM.

Ports:
- CLK_96M  in  1  sole clock; all logic on the rising edge.
- RESET_N  in  1  asynchronous, active-low reset.
- FLUSH  in  1  level; while high, all line buffers are invalid (asserted during ROM download).
- addr_a / addr_b / addr_c  in  21 each  32-bit-word address; held stable while the request is pending.
- req_a / req_b / req_c  in  1 each  toggle; a request is pending when req_x != rdy_x.
- data_a / data_b / data_c  out  32 each  read data; valid from the rdy_x toggle until the next request completes.
- rdy_a / rdy_b / rdy_c  out  1 each  toggle; made equal to req_x on completion.
- sdr_addr  out  25  byte address, always 8-byte aligned.
- sdr_req  out  1  toggle to the SDRAM controller.
- sdr_rdy  in  1  toggle from the controller; sdr_rdy == sdr_req means idle/done.
- sdr_data  in  64  line data; valid in the cycle sdr_rdy becomes equal to sdr_req.

## Operation
- Pending: pend_x = req_x ^ rdy_x.
- Line tag per requester: tag_x[19:0] = addr_x[20:1], plus valid_x. FLUSH or reset clears all valid_x.
- Hit: pend_x && valid_x && tag_x == addr_x[20:1]. A hit bypasses arbitration and SDRAM.
- FSM states: IDLE, ISSUE, WAIT.
- IDLE:
  - Serve at most one hit per cycle, lowest index first (a over b over c). Drive data_x from the buffer half, toggle rdy_x.
  - Otherwise, if any non-hit pending exists, grant round-robin starting at the index after last_grant. Latch grant and go to ISSUE.
- ISSUE:
  - sdr_addr <= BASE_ADDR + {addr_g[20:1], 3'b000}.
  - Toggle sdr_req.
  - Go to WAIT.
- WAIT: on sdr_rdy == sdr_req:
  - Store sdr_data into line_g; tag_g <= addr_g[20:1]; valid_g <= ~FLUSH.
  - data_g <= addr_g[0] ? sdr_data[63:32] : sdr_data[31:0]; toggle rdy_g.
  - last_grant <= g; return to IDLE.
- Hits for non-granted requesters are also served during ISSUE and WAIT. The granted requester is never hit-served.
- Width rules:
  - sdr_addr addition is 25-bit and wraps modulo 2^25.
  - Half select is addr[0]: 0 selects the low word, 1 the high word.
- A requester that toggles req_x again before its rdy_x toggle violates protocol:
  - If not yet granted, the request silently cancels.
  - If already granted, it completes and the mismatch is treated as a new request.
- FLUSH asserted during WAIT: the data is still delivered, but the line is stored invalid.
- Reset values:
  - rdy_x = 0, data_x = 0, sdr_req = 0, sdr_addr = 0.
  - State = IDLE, last_grant = c (so a wins first), all valid_x = 0.
- The SDRAM controller must be reset together with this block. Reset during WAIT abandons the access.

## Timing
- Hit: rdy_x toggles on the 1st rising edge after the req_x toggle is visible (1-cycle latency).
- Miss, idle port: IDLE (grant) → ISSUE (sdr_req toggles on the edge ending ISSUE) → WAIT.
  - rdy_x toggles on the same edge that samples sdr_rdy == sdr_req.
  - Overhead is 3 cycles plus SDRAM latency.
- Back-to-back: after WAIT completes, the next grant is evaluated in the IDLE cycle that follows. Gap is 1 cycle.
- Fairness: with all three continuously missing, grants are a, b, c, a, ...; no requester waits more than 2 foreign accesses.
- Simultaneous hit and miss in IDLE: the hit is served and the grant is made in the same cycle.

## Structure
- Shared package board_b_d_pkg:
  - enum gfx_arb_state_t {IDLE, ISSUE, WAIT}.
  - Constant GFX_REQUESTERS = 3.
  - Typedef gfx_line_t (64-bit).
- Sub-module gfx_line_buf: one per requester. Holds tag, valid and 64-bit line; provides the hit compare and half-select. Three instances in a generate loop.
- Arbiter FSM and round-robin pointer live in the top module.

## Test plan
- Reset, then req_a toggle with addr_a=21'h000005. Required:
  - sdr_addr = BASE_ADDR + 25'h10.
  - Model returns 64'hDEADBEEF_12345678 after 4 cycles.
  - data_a = 32'hDEADBEEF and rdy_a toggles on the same edge.
- Same requester toggles again with addr_a=21'h000004: no sdr_req toggle; data_a = 32'h12345678 one cycle later.
- req_a, req_b and req_c toggled in the same cycle, all misses: SDRAM order is a, b, c; sdr_req toggles exactly 3 times.
- A held in a miss loop and b hitting every cycle during A's WAIT: each b request completes in 1 cycle; A is unaffected.
- FLUSH pulse after a fill, then the same addr_a: an SDRAM access is reissued (miss).
- RESET_N asserted during WAIT: all rdy_x = 0, sdr_req = 0, state IDLE. The first request after release goes through the SDRAM.

Source files
------------

// File: rtl/board_b_d_pkg.sv
// Shared types and constants for the B-D graphics ROM arbiter.
// Holds the arbiter state encoding, line type and round-robin helper.
package board_b_d_pkg;

    localparam int GFX_REQUESTERS = 3;
    localparam int GFX_TAG_W      = 20;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } gfx_arb_state_t;

    typedef logic [63:0] gfx_line_t;

    // Next requester index in round-robin order, wrapping after the last one.
    function automatic logic [1:0] rr_next(input logic [1:0] idx);
        return (idx == 2'(GFX_REQUESTERS - 1)) ? 2'd0 : idx + 2'd1;
    endfunction

endpackage

// File: rtl/gfx_line_buf.sv
// One-line (64-bit) read buffer for a single tile fetcher: tag, valid flag,
// hit compare against the current word address and 32-bit half select.
module gfx_line_buf
    import board_b_d_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        flush_i,
    input  logic [20:0] addr_i,
    input  logic        fill_i,
    input  gfx_line_t   fill_data_i,
    output logic        hit_o,
    output logic [31:0] half_o
);

    logic [GFX_TAG_W-1:0] tag_q, tag_d;
    logic                 valid_q, valid_d;
    gfx_line_t            line_q, line_d;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            tag_q   <= '0;
            valid_q <= 1'b0;
            line_q  <= '0;
        end else begin
            tag_q   <= tag_d;
            valid_q <= valid_d;
            line_q  <= line_d;
        end
    end

    always_comb begin
        tag_d   = tag_q;
        valid_d = valid_q;
        line_d  = line_q;
        if (fill_i) begin
            tag_d   = addr_i[20:1];
            line_d  = fill_data_i;
            valid_d = 1'b1;
        end
        // A fill that lands while flushing still delivers data but stays invalid.
        if (flush_i) begin
            valid_d = 1'b0;
        end
    end

    assign hit_o  = valid_q && !flush_i && (tag_q == addr_i[20:1]);
    assign half_o = addr_i[0] ? line_q[63:32] : line_q[31:0];

endmodule

// File: rtl/board_b_d_gfx_arb.sv
// Shares one 64-bit graphics-ROM SDRAM channel between the three B-D playfield
// fetchers with toggle handshakes, round-robin grants and per-requester line buffers.
module board_b_d_gfx_arb
    import board_b_d_pkg::*;
#(
    parameter logic [24:0] BASE_ADDR = 25'h0
) (
    input  logic        CLK_96M,
    input  logic        RESET_N,
    input  logic        FLUSH,
    input  logic [20:0] addr_a,
    input  logic [20:0] addr_b,
    input  logic [20:0] addr_c,
    input  logic        req_a,
    input  logic        req_b,
    input  logic        req_c,
    output logic [31:0] data_a,
    output logic [31:0] data_b,
    output logic [31:0] data_c,
    output logic        rdy_a,
    output logic        rdy_b,
    output logic        rdy_c,
    output logic [24:0] sdr_addr,
    output logic        sdr_req,
    input  logic        sdr_rdy,
    input  logic [63:0] sdr_data
);

    gfx_arb_state_t state_q, state_d;
    logic [1:0]     grant_q, grant_d;
    logic [1:0]     last_q, last_d;
    logic           sdr_req_q, sdr_req_d;
    logic [24:0]    sdr_addr_q, sdr_addr_d;

    logic [GFX_REQUESTERS-1:0] rdy_q, rdy_d;
    logic [31:0]               data_q [GFX_REQUESTERS];
    logic [31:0]               data_d [GFX_REQUESTERS];

    logic [20:0]               addr_v    [GFX_REQUESTERS];
    logic [31:0]               half_data [GFX_REQUESTERS];
    logic [GFX_REQUESTERS-1:0] req_v, pend, hit_match, hit_ok, miss, fill_en, granted_oh;

    logic       served;
    logic       rr_found;
    logic [1:0] rr_pick, rr_cur;

    assign addr_v[0] = addr_a;
    assign addr_v[1] = addr_b;
    assign addr_v[2] = addr_c;
    assign req_v     = {req_c, req_b, req_a};

    assign pend       = req_v ^ rdy_q;
    assign granted_oh = (state_q != IDLE) ? (3'b001 << grant_q) : 3'b000;
    assign hit_ok     = pend & hit_match & ~granted_oh;
    assign miss       = pend & ~hit_match;

    generate
        for (genvar gi = 0; gi < GFX_REQUESTERS; gi++) begin : g_line
            gfx_line_buf u_line_buf (
                .clk_i       (CLK_96M),
                .rst_ni      (RESET_N),
                .flush_i     (FLUSH),
                .addr_i      (addr_v[gi]),
                .fill_i      (fill_en[gi]),
                .fill_data_i (sdr_data),
                .hit_o       (hit_match[gi]),
                .half_o      (half_data[gi])
            );
        end
    endgenerate

    // Round-robin search starts at the requester after the last completed grant.
    always_comb begin
        rr_found = 1'b0;
        rr_pick  = last_q;
        rr_cur   = last_q;
        for (int k = 0; k < GFX_REQUESTERS; k++) begin
            rr_cur = rr_next(rr_cur);
            if (miss[rr_cur] && !rr_found) begin
                rr_found = 1'b1;
                rr_pick  = rr_cur;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        last_d     = last_q;
        sdr_req_d  = sdr_req_q;
        sdr_addr_d = sdr_addr_q;
        rdy_d      = rdy_q;
        data_d     = data_q;
        fill_en    = '0;
        served     = 1'b0;

        // Buffer hits never touch SDRAM and run alongside any access in flight.
        for (int i = 0; i < GFX_REQUESTERS; i++) begin
            if (hit_ok[i] && !served) begin
                served    = 1'b1;
                rdy_d[i]  = ~rdy_q[i];
                data_d[i] = half_data[i];
            end
        end

        case (state_q)
            IDLE: begin
                if (rr_found) begin
                    grant_d = rr_pick;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                sdr_addr_d = BASE_ADDR + {2'b00, addr_v[grant_q][20:1], 3'b000};
                sdr_req_d  = ~sdr_req_q;
                state_d    = WAIT;
            end
            WAIT: begin
                if (sdr_rdy == sdr_req_q) begin
                    fill_en[grant_q] = 1'b1;
                    rdy_d[grant_q]   = ~rdy_q[grant_q];
                    data_d[grant_q]  = addr_v[grant_q][0] ? sdr_data[63:32] : sdr_data[31:0];
                    last_d           = grant_q;
                    state_d          = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK_96M or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q    <= IDLE;
            grant_q    <= 2'd0;
            last_q     <= 2'(GFX_REQUESTERS - 1);
            sdr_req_q  <= 1'b0;
            sdr_addr_q <= '0;
            rdy_q      <= '0;
            for (int i = 0; i < GFX_REQUESTERS; i++) begin
                data_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            last_q     <= last_d;
            sdr_req_q  <= sdr_req_d;
            sdr_addr_q <= sdr_addr_d;
            rdy_q      <= rdy_d;
            data_q     <= data_d;
        end
    end

    assign data_a   = data_q[0];
    assign data_b   = data_q[1];
    assign data_c   = data_q[2];
    assign rdy_a    = rdy_q[0];
    assign rdy_b    = rdy_q[1];
    assign rdy_c    = rdy_q[2];
    assign sdr_req  = sdr_req_q;
    assign sdr_addr = sdr_addr_q;

endmodule
